wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/core_types_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/wb_arbiter.sv | 76 +++++++
 tb/tb_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: writeback request bundle and sizing constants.
// Used by the writeback arbiter and its interface.
package core_types_pkg;

    localparam int WB_PIPE_COUNT = 4;
    localparam int LOG_PR_COUNT  = 6;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             data;
        logic [LOG_PR_COUNT-1:0] pr;
    } wb_req_t;

    function automatic logic is_zero_pr(input logic [LOG_PR_COUNT-1:0] pr);
        return pr == '0;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: per-pipe requests in, one PRF write port out.
// master = pipes + PRF side, slave = the arbiter.
interface wb_arbiter_if
    import core_types_pkg::*;
#(
    parameter int PIPES = WB_PIPE_COUNT,
    parameter int PRW   = LOG_PR_COUNT
);
    logic [PIPES-1:0]           WB_valid_by_pipe;
    logic [PIPES-1:0][31:0]     WB_data_by_pipe;
    logic [PIPES-1:0][PRW-1:0]  WB_PR_by_pipe;
    logic [PIPES-1:0]           WB_ack_by_pipe;
    logic                       PRF_WR_ready_in;
    logic                       PRF_WR_valid_out;
    logic [31:0]                PRF_WR_data_out;
    logic [PRW-1:0]             PRF_WR_PR_out;

    modport master (
        output WB_valid_by_pipe,
        output WB_data_by_pipe,
        output WB_PR_by_pipe,
        input  WB_ack_by_pipe,
        output PRF_WR_ready_in,
        input  PRF_WR_valid_out,
        input  PRF_WR_data_out,
        input  PRF_WR_PR_out
    );

    modport slave (
        input  WB_valid_by_pipe,
        input  WB_data_by_pipe,
        input  WB_PR_by_pipe,
        output WB_ack_by_pipe,
        input  PRF_WR_ready_in,
        output PRF_WR_valid_out,
        output PRF_WR_data_out,
        output PRF_WR_PR_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer wins,
// pointer moves past the winner; grant forced low while disabled or in reset.
module rr_arbiter #(
    parameter int REQ_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_COUNT-1:0] req,
    input  logic                 en,
    output logic [REQ_COUNT-1:0] grant
);

    localparam int PW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          hit;

    // Scan requesters starting at the pointer, wrapping once.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx = PW'((int'(ptr) + k) % REQ_COUNT);
            if (!hit && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                hit        = 1'b1;
            end
        end
        if (!en || rst) begin
            grant = '0;
            hit   = 1'b0;
        end
    end

    // Pointer advances to the slot after the winner; holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (hit) begin
            if (int'(win) == REQ_COUNT - 1)
                ptr <= '0;
            else
                ptr <= win + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: funnels per-pipe results into one registered PRF write.
// Optional WB_ARB_ZERO_PR_DROP_EN: grants to PR 0 are acked but not written.
module wb_arbiter #(
    parameter int WB_PIPE_COUNT = core_types_pkg::WB_PIPE_COUNT,
    parameter int LOG_PR_COUNT  = core_types_pkg::LOG_PR_COUNT
) (
    input  logic        CLK,
    input  logic        RST,
    wb_arbiter_if.slave bus
);

    import core_types_pkg::*;

    logic                     free;
    logic [WB_PIPE_COUNT-1:0] grant;
    logic                     load;
    wb_req_t                  sel;

    logic                     out_valid;
    logic [31:0]              out_data;
    logic [LOG_PR_COUNT-1:0]  out_pr;

    // Output slot can take a new entry when empty or draining this cycle.
    assign free = !out_valid || bus.PRF_WR_ready_in;

    rr_arbiter #(
        .REQ_COUNT(WB_PIPE_COUNT)
    ) u_rr (
        .clk  (CLK),
        .rst  (RST),
        .req  (bus.WB_valid_by_pipe),
        .en   (free),
        .grant(grant)
    );

    assign bus.WB_ack_by_pipe = grant;

    // Pick the granted pipe's payload; grant is one-hot or zero.
    always_comb begin
        sel = '0;
        for (int i = 0; i < WB_PIPE_COUNT; i++) begin
            if (grant[i]) begin
                sel.valid = 1'b1;
                sel.data  = bus.WB_data_by_pipe[i];
                sel.pr    = bus.WB_PR_by_pipe[i];
            end
        end
    end

    // Decide whether the granted request actually occupies the output slot.
`ifdef WB_ARB_ZERO_PR_DROP_EN
    assign load = sel.valid && !is_zero_pr(sel.pr);
`else
    assign load = sel.valid;
`endif

    // Output register: load on grant, clear valid when idle, hold on stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pr    <= '0;
        end else if (free) begin
            out_valid <= load;
            if (load) begin
                out_data <= sel.data;
                out_pr   <= sel.pr;
            end
        end
    end

    assign bus.PRF_WR_valid_out = out_valid;
    assign bus.PRF_WR_data_out  = out_data;
    assign bus.PRF_WR_PR_out    = out_pr;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-pipe request FIFOs, a transaction-level
// reference model checked every cycle, plus literal scenario checks.
module tb_wb_arbiter;

    import core_types_pkg::*;

    localparam int NP = WB_PIPE_COUNT;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0]             d;
        logic [LOG_PR_COUNT-1:0] pr;
    } ent_t;

    logic CLK;
    logic RST;
    logic ready;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    assign bus.PRF_WR_ready_in = ready;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // pending requests per pipe
    ent_t fifo [NP][DEPTH];
    int   hd [NP];
    int   tl [NP];

    // reference model of the output slot and rotation pointer
    logic                    m_valid;
    logic [31:0]             m_data;
    logic [LOG_PR_COUNT-1:0] m_pr;
    int                      m_p;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    // DUT observation logs
    int glog [256];
    int gcyc [256];
    int gn = 0;
    int wlog [256];
    int wn = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NP; i++)
            if (hd[i] != tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    // First pipe with a pending request at or after p, wrapping.
    function automatic int pick(input int p);
        for (int k = 0; k < NP; k++) begin
            int j;
            j = (p + k) % NP;
            if (hd[j] != tl[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_pipes();
        for (int i = 0; i < NP; i++) begin
            if (hd[i] != tl[i]) begin
                bus.WB_valid_by_pipe[i] = 1'b1;
                bus.WB_data_by_pipe[i]  = fifo[i][hd[i] % DEPTH].d;
                bus.WB_PR_by_pipe[i]    = fifo[i][hd[i] % DEPTH].pr;
            end else begin
                bus.WB_valid_by_pipe[i] = 1'b0;
                bus.WB_data_by_pipe[i]  = '0;
                bus.WB_PR_by_pipe[i]    = '0;
            end
        end
    endtask

    task automatic push(input int i, input logic [31:0] d, input int pr);
        fifo[i][tl[i] % DEPTH].d  = d;
        fifo[i][tl[i] % DEPTH].pr = LOG_PR_COUNT'(pr);
        tl[i]++;
        drive_pipes();
    endtask

    always @(posedge CLK) cyc++;

    // Model step: an accepted request moves into the slot, the pipe pops.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_pr    = '0;
            m_p     = 0;
        end else if (!m_valid || ready) begin
            int w;
            w = pick(m_p);
            if (w >= 0) begin
                ent_t e;
                e = fifo[w][hd[w] % DEPTH];
                hd[w]++;
                m_p = (w + 1) % NP;
`ifdef WB_ARB_ZERO_PR_DROP_EN
                m_valid = (e.pr != 0);
`else
                m_valid = 1'b1;
`endif
                if (m_valid) begin
                    m_data = e.d;
                    m_pr   = e.pr;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Requests change only after the model has consumed the edge.
    always @(posedge CLK) begin
        #1;
        drive_pipes();
    end

    // Per-cycle comparison against the model, plus DUT logs.
    always @(negedge CLK) begin
        logic [NP-1:0] exp_ack;
        int w;
        exp_ack = '0;
        if (!RST && (!m_valid || ready)) begin
            w = pick(m_p);
            if (w >= 0) exp_ack[w] = 1'b1;
        end
        check("ack", 32'(bus.WB_ack_by_pipe), 32'(exp_ack));
        check("valid_out", 32'(bus.PRF_WR_valid_out), 32'(m_valid));
        check("data_out", bus.PRF_WR_data_out, m_data);
        check("pr_out", 32'(bus.PRF_WR_PR_out), 32'(m_pr));
        if (!RST && bus.WB_ack_by_pipe != 0 && gn < 256) begin
            for (int i = 0; i < NP; i++)
                if (bus.WB_ack_by_pipe[i]) glog[gn] = i;
            gcyc[gn] = cyc;
            gn++;
        end
        if (!RST && bus.PRF_WR_valid_out && ready && wn < 256) begin
            wlog[wn] = int'(bus.PRF_WR_PR_out);
            wn++;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((pending() || m_valid) && n < 200) begin
            @(posedge CLK);
            n++;
        end
        check(nm, 32'(n < 200), 32'd1);
        @(posedge CLK);
        #2;
    endtask

    int gb;
    int wb;

    initial begin
        for (int i = 0; i < NP; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        ready = 1'b1;
        RST = 1'b0;
        drive_pipes();
        #1 RST = 1'b1;

        // reset held with every pipe requesting; then in-order drain
        gb = gn;
        wb = wn;
        for (int i = 0; i < NP; i++)
            push(i, 32'hA0 + 32'(i), 5 + i);
        repeat (3) begin
            @(negedge CLK);
            check("rst_ack", 32'(bus.WB_ack_by_pipe), 32'd0);
            check("rst_valid", 32'(bus.PRF_WR_valid_out), 32'd0);
            check("rst_pr", 32'(bus.PRF_WR_PR_out), 32'd0);
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        wait_idle("s1_timeout");
        check("s1_ngrant", 32'(gn - gb), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("s1_grant", 32'(glog[gb + k]), 32'(k));
            check("s1_wr_pr", 32'(wlog[wb + k]), 32'(5 + k));
        end
        check("s1_back2back", 32'(gcyc[gb + 3] - gcyc[gb]), 32'd3);

        // stall with a held entry, then release
        gb = gn;
        wb = wn;
        ready = 1'b0;
        push(2, 32'hDEADBEEF, 9);
        @(posedge CLK);
        #2 push(0, 32'h55, 10);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("s2_hold_valid", 32'(bus.PRF_WR_valid_out), 32'd1);
        check("s2_hold_data", bus.PRF_WR_data_out, 32'hDEADBEEF);
        check("s2_hold_pr", 32'(bus.PRF_WR_PR_out), 32'd9);
        check("s2_one_ack", 32'(gn - gb), 32'd1);
        @(posedge CLK);
        #2 ready = 1'b1;
        wait_idle("s2_timeout");
        check("s2_nwr", 32'(wn - wb), 32'd2);
        check("s2_wr0", 32'(wlog[wb]), 32'd9);
        check("s2_wr1", 32'(wlog[wb + 1]), 32'd10);

        // wrap-around: pointer left at 3 by a grant to pipe 2
        gb = gn;
        push(2, 32'h22, 11);
        wait_idle("s3a_timeout");
        push(0, 32'h30, 12);
        push(3, 32'h33, 13);
        wait_idle("s3b_timeout");
        check("s3_ngrant", 32'(gn - gb), 32'd3);
        check("s3_first", 32'(glog[gb + 1]), 32'd3);
        check("s3_second", 32'(glog[gb + 2]), 32'd0);

        // PR 0 request followed by PR 4
        gb = gn;
        wb = wn;
        push(1, 32'h111, 0);
        push(2, 32'h222, 4);
        wait_idle("s4_timeout");
        check("s4_ngrant", 32'(gn - gb), 32'd2);
`ifdef WB_ARB_ZERO_PR_DROP_EN
        check("s4_nwr", 32'(wn - wb), 32'd1);
        check("s4_wr0", 32'(wlog[wb]), 32'd4);
`else
        check("s4_nwr", 32'(wn - wb), 32'd2);
        check("s4_wr0", 32'(wlog[wb]), 32'd0);
        check("s4_wr1", 32'(wlog[wb + 1]), 32'd4);
`endif

        // reset in the middle of a stall discards the held entry
        gb = gn;
        wb = wn;
        ready = 1'b0;
        push(2, 32'hC2, 12);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("s5_held_valid", 32'(bus.PRF_WR_valid_out), 32'd1);
        check("s5_held_pr", 32'(bus.PRF_WR_PR_out), 32'd12);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("s5_async_valid", 32'(bus.PRF_WR_valid_out), 32'd0);
        check("s5_async_pr", 32'(bus.PRF_WR_PR_out), 32'd0);
        push(1, 32'hB1, 14);
        push(3, 32'hB3, 15);
        ready = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        wait_idle("s5_timeout");
        check("s5_ngrant", 32'(gn - gb), 32'd3);
        check("s5_first", 32'(glog[gb + 1]), 32'd1);
        check("s5_second", 32'(glog[gb + 2]), 32'd3);
        check("s5_nwr", 32'(wn - wb), 32'd2);
        check("s5_wr0", 32'(wlog[wb]), 32'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
